// File: rtl/pixel_readout_capture_pkg.sv
// Shared definitions for the pixel readout capture block: sizing defaults, row indices,
// sequencing states and the column-index width helper.
package pixel_readout_capture_pkg;

    localparam int PIX_DW_DEFAULT   = 8;
    localparam int PIX_COLS_DEFAULT = 2;

    localparam logic ROW0 = 1'b0;
    localparam logic ROW1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_STREAM
    } cap_state_t;

    // Column index is at least one bit wide even for a single-column sensor.
    function automatic int col_width(input int cols);
        return (cols > 1) ? $clog2(cols) : 1;
    endfunction

endpackage

// File: rtl/pixel_readout_capture_rise_detect.sv
// Registered rising-edge detector: one-cycle pulse the cycle after the input is first
// sampled high.
module pixel_readout_capture_rise_detect (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            d_q  <= 1'b0;
            rise <= 1'b0;
        end else begin
            d_q  <= d;
            rise <= d & ~d_q;
        end
    end

endmodule

// File: rtl/pixel_readout_capture.sv
// Receive side of the camera sequencing interface: captures column ADC codes per row into
// a two-row buffer, then streams the frame out in raster order over valid/ready.
module pixel_readout_capture
    import pixel_readout_capture_pkg::*;
#(
    parameter int DW   = PIX_DW_DEFAULT,
    parameter int COLS = PIX_COLS_DEFAULT
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        Erase,
    input  logic                        Expose,
    input  logic                        NRE_1,
    input  logic                        NRE_2,
    input  logic                        ADC,
    input  logic [COLS*DW-1:0]          Adc_data,
    output logic [DW-1:0]               Pix_data,
    output logic                        Pix_row,
    output logic [col_width(COLS)-1:0]  Pix_col,
    output logic                        Pix_valid,
    input  logic                        Pix_ready,
    output logic                        Frame_done,
    output logic                        Overflow,
    output logic                        Seq_error
);

    localparam int              CW       = col_width(COLS);
    localparam logic [CW-1:0]   LAST_COL = CW'(COLS - 1);

    cap_state_t state, state_next;

    logic               adc_rise;
    logic               expose_rise;
    logic               expose_seen;
    logic [COLS*DW-1:0] adc_stage;
    logic               nre1_stage;
    logic               nre2_stage;
    logic [COLS*DW-1:0] row_buf [2];
    logic [COLS*DW-1:0] cur_row;
    logic [1:0]         row_flag;
    logic [CW-1:0]      col_idx;
    logic               row_idx;
    logic               strobe_legal;
    logic               strobe_row;
    logic               handshake;
    logic               last_pix;
    logic               capture_en;
    logic               clear_flags;
    logic               overflow_set;

    pixel_readout_capture_rise_detect u_adc_rise (
        .clock (Clk),
        .reset (Reset),
        .d     (ADC),
        .rise  (adc_rise)
    );

    pixel_readout_capture_rise_detect u_expose_rise (
        .clock (Clk),
        .reset (Reset),
        .d     (Expose),
        .rise  (expose_rise)
    );

    // Row enables and codes are delayed one cycle so they line up with the registered ADC pulse.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            adc_stage  <= '0;
            nre1_stage <= 1'b1;
            nre2_stage <= 1'b1;
        end else begin
            adc_stage  <= Adc_data;
            nre1_stage <= NRE_1;
            nre2_stage <= NRE_2;
        end
    end

    assign strobe_legal = nre1_stage ^ nre2_stage;
    assign strobe_row   = nre1_stage ? ROW1 : ROW0;
    assign Pix_valid    = (state == ST_STREAM);
    assign handshake    = Pix_valid & Pix_ready;
    assign last_pix     = (row_idx == ROW1) && (col_idx == LAST_COL);

    always_comb begin
        state_next   = state;
        capture_en   = 1'b0;
        clear_flags  = 1'b0;
        overflow_set = 1'b0;
        Seq_error    = 1'b0;
        Frame_done   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Erase) begin
                    clear_flags = 1'b1;
                    state_next  = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (Erase) begin
                    clear_flags = 1'b1;
                end else if (expose_seen && !Expose) begin
                    state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                // Erase abandons the partial frame and takes priority over any strobe.
                if (Erase) begin
                    clear_flags = 1'b1;
                    state_next  = ST_ARMED;
                end else begin
                    if (adc_rise) begin
                        capture_en = strobe_legal;
                        Seq_error  = ~strobe_legal;
                    end
                    if (&row_flag) begin
                        state_next = ST_STREAM;
                    end
                end
            end
            ST_STREAM: begin
                overflow_set = adc_rise & strobe_legal;
                if (handshake && last_pix) begin
                    Frame_done = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= ST_IDLE;
            row_flag    <= '0;
            expose_seen <= 1'b0;
            Overflow    <= 1'b0;
        end else begin
            state <= state_next;
            if (clear_flags) begin
                row_flag <= '0;
            end else if (capture_en) begin
                row_flag[strobe_row] <= 1'b1;
            end
            if (state != ST_ARMED || clear_flags) begin
                expose_seen <= 1'b0;
            end else if (expose_rise) begin
                expose_seen <= 1'b1;
            end
            if (overflow_set) begin
                Overflow <= 1'b1;
            end
        end
    end

    // Frame contents need no reset; the row flags decide when they are meaningful.
    always_ff @(posedge Clk) begin
        if (capture_en) begin
            row_buf[strobe_row] <= adc_stage;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset || state != ST_STREAM) begin
            col_idx <= '0;
            row_idx <= ROW0;
        end else if (handshake) begin
            if (col_idx == LAST_COL) begin
                col_idx <= '0;
                row_idx <= ~row_idx;
            end else begin
                col_idx <= col_idx + CW'(1);
            end
        end
    end

    assign cur_row  = row_buf[row_idx];
    assign Pix_data = Pix_valid ? cur_row[int'(col_idx)*DW +: DW] : '0;
    assign Pix_row  = Pix_valid & row_idx;
    assign Pix_col  = Pix_valid ? col_idx : '0;

endmodule

// File: tb/tb_pixel_readout_capture.sv
// Bench for pixel_readout_capture with DW=8, COLS=2.
module tb_pixel_readout_capture;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Erase;
    logic        Expose;
    logic        NRE_1;
    logic        NRE_2;
    logic        ADC;
    logic [15:0] Adc_data;
    logic [7:0]  Pix_data;
    logic        Pix_row;
    logic        Pix_col;
    logic        Pix_valid;
    logic        Pix_ready;
    logic        Frame_done;
    logic        Overflow;
    logic        Seq_error;

    int vectors        = 0;
    int miscompares    = 0;
    int seq_err_pulses = 0;

    typedef struct packed {
        logic        erase;
        logic        expose;
        logic        nre1;
        logic        nre2;
        logic        adc;
        logic        ready;
        logic [15:0] data;
        logic        exp_valid;
        logic [7:0]  exp_data;
        logic        exp_row;
        logic        exp_col;
        logic        exp_done;
        logic        exp_ovf;
        logic        exp_seq;
    } vec_t;

    vec_t tbl[$];

    pixel_readout_capture #(.DW(8), .COLS(2)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Erase      (Erase),
        .Expose     (Expose),
        .NRE_1      (NRE_1),
        .NRE_2      (NRE_2),
        .ADC        (ADC),
        .Adc_data   (Adc_data),
        .Pix_data   (Pix_data),
        .Pix_row    (Pix_row),
        .Pix_col    (Pix_col),
        .Pix_valid  (Pix_valid),
        .Pix_ready  (Pix_ready),
        .Frame_done (Frame_done),
        .Overflow   (Overflow),
        .Seq_error  (Seq_error)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (Seq_error === 1'b1) seq_err_pulses++;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        Erase     = v.erase;
        Expose    = v.expose;
        NRE_1     = v.nre1;
        NRE_2     = v.nre2;
        ADC       = v.adc;
        Pix_ready = v.ready;
        Adc_data  = v.data;
    endtask

    function automatic void add_vec(input int n, input logic erase, input logic expose,
                                    input logic nre1, input logic nre2, input logic adc,
                                    input logic [15:0] data, input logic exp_valid,
                                    input logic [7:0] exp_data, input logic exp_row,
                                    input logic exp_col, input logic exp_done);
        vec_t v;
        v = '{erase: erase, expose: expose, nre1: nre1, nre2: nre2, adc: adc, ready: 1'b1,
              data: data, exp_valid: exp_valid, exp_data: exp_data, exp_row: exp_row,
              exp_col: exp_col, exp_done: exp_done, exp_ovf: 1'b0, exp_seq: 1'b0};
        repeat (n) tbl.push_back(v);
    endfunction

    task automatic expose_to_capture(input int n);
        Expose = 1'b1;
        repeat (n) tick();
        Expose = 1'b0;
        repeat (2) tick();
    endtask

    task automatic run_to_capture(input int n);
        Erase = 1'b1;
        tick();
        Erase = 1'b0;
        expose_to_capture(n);
    endtask

    task automatic strobe(input logic nre1, input logic nre2, input logic [15:0] data,
                          input logic erase, output logic seq_seen);
        NRE_1    = nre1;
        NRE_2    = nre2;
        Adc_data = data;
        ADC      = 1'b1;
        Erase    = erase;
        tick();
        ADC   = 1'b0;
        NRE_1 = 1'b1;
        NRE_2 = 1'b1;
        Erase = 1'b0;
        #1;
        seq_seen = Seq_error;
        tick();
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (Pix_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checkOutput({tag, " valid"}, 32'(Pix_valid), 32'd1);
    endtask

    // mode 0: always ready, 1: ready toggling, 2: random ready
    task automatic drain_frame(input logic [15:0] r0, input logic [15:0] r1,
                               input int mode, input string tag);
        logic [7:0] exp_pix [4];
        int         idx  = 0;
        int         cyc  = 0;
        bit         held = 0;
        logic [9:0] held_val = '0;
        exp_pix[0] = r0[7:0];
        exp_pix[1] = r0[15:8];
        exp_pix[2] = r1[7:0];
        exp_pix[3] = r1[15:8];
        while (idx < 4 && cyc < 100) begin
            case (mode)
                0:       Pix_ready = 1'b1;
                1:       Pix_ready = (cyc % 2 == 0);
                default: Pix_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (Pix_valid === 1'b1) begin
                if (held) begin
                    checkOutput({tag, " hold"}, 32'({Pix_data, Pix_row, Pix_col}), 32'(held_val));
                end
                if (Pix_ready) begin
                    checkOutput($sformatf("%s pix%0d", tag, idx),
                                32'({Pix_data, Pix_row, Pix_col, Frame_done}),
                                32'({exp_pix[idx], idx[1], idx[0], idx == 3}));
                    idx++;
                    held = 0;
                end else begin
                    held     = 1;
                    held_val = {Pix_data, Pix_row, Pix_col};
                end
            end
            tick();
            cyc++;
        end
        checkOutput({tag, " pixel count"}, 32'(idx), 32'd4);
        checkOutput({tag, " valid after frame"}, 32'(Pix_valid), 32'd0);
        Pix_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] rows [2];
        logic        seq;
        logic        exp_ovf;
        int          first;
        int          n_ev;
        int          seq_base;
        int          exp_seq;
        int          r;

        Reset     = 1'b1;
        Erase     = 1'b0;
        Expose    = 1'b0;
        NRE_1     = 1'b1;
        NRE_2     = 1'b1;
        ADC       = 1'b0;
        Adc_data  = '0;
        Pix_ready = 1'b0;
        repeat (2) tick();
        checkOutput("reset outputs",
                    32'({Pix_valid, Pix_data, Pix_row, Pix_col, Frame_done, Overflow, Seq_error}), 32'd0);
        Reset = 1'b0;

        // basic frame, cycle by cycle
        add_vec(1,  1, 0, 1, 1, 0, 16'h0000, 0, 8'h00, 0, 0, 0);
        add_vec(10, 0, 1, 1, 1, 0, 16'h0000, 0, 8'h00, 0, 0, 0);
        add_vec(1,  0, 0, 1, 1, 0, 16'h0000, 0, 8'h00, 0, 0, 0);
        add_vec(1,  0, 0, 0, 1, 1, 16'hA53C, 0, 8'h00, 0, 0, 0);
        add_vec(1,  0, 0, 1, 1, 0, 16'h0000, 0, 8'h00, 0, 0, 0);
        add_vec(1,  0, 0, 1, 0, 1, 16'h0FF0, 0, 8'h00, 0, 0, 0);
        add_vec(2,  0, 0, 1, 1, 0, 16'h0000, 0, 8'h00, 0, 0, 0);
        add_vec(1,  0, 0, 1, 1, 0, 16'h0000, 1, 8'h3C, 0, 0, 0);
        add_vec(1,  0, 0, 1, 1, 0, 16'h0000, 1, 8'hA5, 0, 1, 0);
        add_vec(1,  0, 0, 1, 1, 0, 16'h0000, 1, 8'hF0, 1, 0, 0);
        add_vec(1,  0, 0, 1, 1, 0, 16'h0000, 1, 8'h0F, 1, 1, 1);
        add_vec(1,  0, 0, 1, 1, 0, 16'h0000, 0, 8'h00, 0, 0, 0);
        foreach (tbl[i]) begin
            applyStimulus(tbl[i]);
            #2;
            checkOutput($sformatf("table v%0d", i),
                        32'({Pix_valid, Pix_data, Pix_row, Pix_col, Frame_done, Overflow, Seq_error}),
                        32'({tbl[i].exp_valid, tbl[i].exp_data, tbl[i].exp_row, tbl[i].exp_col,
                             tbl[i].exp_done, tbl[i].exp_ovf, tbl[i].exp_seq}));
            tick();
        end
        Pix_ready = 1'b0;

        // same frame with ready toggling
        run_to_capture(10);
        strobe(0, 1, 16'hA53C, 0, seq);
        strobe(1, 0, 16'h0FF0, 0, seq);
        drain_frame(16'hA53C, 16'h0FF0, 1, "t2");

        // illegal strobes
        run_to_capture(3);
        strobe(0, 0, 16'h1234, 0, seq);
        checkOutput("t3 both-low seq_error", 32'(seq), 32'd1);
        checkOutput("t3 seq_error one cycle", 32'(Seq_error), 32'd0);
        strobe(1, 1, 16'h4321, 0, seq);
        checkOutput("t3 both-high seq_error", 32'(seq), 32'd1);
        strobe(1, 0, 16'h5566, 0, seq);
        checkOutput("t3 legal no seq_error", 32'(seq), 32'd0);
        repeat (4) tick();
        checkOutput("t3 no stream on one row", 32'(Pix_valid), 32'd0);
        strobe(0, 1, 16'h7788, 0, seq);
        drain_frame(16'h7788, 16'h5566, 0, "t3");

        // erase mid-capture drops the partial frame
        run_to_capture(4);
        strobe(0, 1, 16'h1111, 0, seq);
        Erase = 1'b1;
        tick();
        Erase = 1'b0;
        expose_to_capture(3);
        strobe(1, 0, 16'h2222, 0, seq);
        repeat (4) tick();
        checkOutput("t5 old row0 discarded", 32'(Pix_valid), 32'd0);
        strobe(1, 0, 16'h9999, 1, seq);
        checkOutput("t5 erase beats strobe", 32'(seq), 32'd0);
        expose_to_capture(3);
        strobe(0, 1, 16'h3333, 0, seq);
        strobe(1, 0, 16'h4444, 0, seq);
        drain_frame(16'h3333, 16'h4444, 0, "t5");

        // legal strobe during stream
        run_to_capture(3);
        strobe(0, 1, 16'hC3B2, 0, seq);
        strobe(1, 0, 16'hE1D0, 0, seq);
        Pix_ready = 1'b0;
        wait_valid("t4");
        strobe(0, 1, 16'hDEAD, 0, seq);
        checkOutput("t4 overflow set", 32'(Overflow), 32'd1);
        checkOutput("t4 held pixel", 32'({Pix_valid, Pix_data, Pix_row, Pix_col}), 32'({1'b1, 8'hB2, 1'b0, 1'b0}));
        drain_frame(16'hC3B2, 16'hE1D0, 0, "t4");
        strobe(0, 1, 16'hBEEF, 0, seq);
        checkOutput("idle strobe no seq_error", 32'(seq), 32'd0);
        checkOutput("t4 overflow sticky", 32'(Overflow), 32'd1);

        // reset mid-stream
        run_to_capture(3);
        strobe(0, 1, 16'h0102, 0, seq);
        strobe(1, 0, 16'h0304, 0, seq);
        wait_valid("t6");
        Pix_ready = 1'b1;
        repeat (2) tick();
        Reset = 1'b1;
        #1;
        checkOutput("t6 no done before reset", 32'(Frame_done), 32'd0);
        tick();
        checkOutput("t6 outputs after reset", 32'({Pix_valid, Frame_done, Overflow}), 32'd0);
        Reset = 1'b0;
        repeat (3) tick();
        checkOutput("t6 idle after reset", 32'(Pix_valid), 32'd0);
        Pix_ready = 1'b0;

        // randomized frames against a transaction-level model
        exp_ovf = 1'b0;
        for (int f = 0; f < 10; f++) begin
            seq_base = seq_err_pulses;
            exp_seq  = 0;
            Erase = 1'b1;
            tick();
            Erase = 1'b0;
            if ($urandom_range(0, 1) == 1) strobe(0, 1, 16'($urandom), 0, seq);
            expose_to_capture($urandom_range(2, 6));
            first = $urandom_range(0, 1);
            rows[first] = 16'($urandom);
            strobe(first != 0, first != 1, rows[first], 0, seq);
            n_ev = $urandom_range(0, 3);
            for (int e = 0; e < n_ev; e++) begin
                if ($urandom_range(0, 1) == 1) begin
                    r = $urandom_range(0, 1);
                    strobe(r == 1, r == 1, 16'($urandom), 0, seq);
                    exp_seq++;
                end else begin
                    rows[first] = 16'($urandom);
                    strobe(first != 0, first != 1, rows[first], 0, seq);
                end
            end
            rows[1 - first] = 16'($urandom);
            strobe(first != 1, first != 0, rows[1 - first], 0, seq);
            if ($urandom_range(0, 2) == 0) begin
                Pix_ready = 1'b0;
                wait_valid($sformatf("rnd%0d", f));
                r = $urandom_range(0, 1);
                strobe(r != 0, r != 1, 16'($urandom), 0, seq);
                exp_ovf = 1'b1;
            end
            drain_frame(rows[0], rows[1], 2, $sformatf("rnd%0d", f));
            checkOutput($sformatf("rnd%0d seq_error count", f), 32'(seq_err_pulses - seq_base), 32'(exp_seq));
            checkOutput($sformatf("rnd%0d overflow", f), 32'(Overflow), 32'(exp_ovf));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
